// File: rtl/setpoint_ramp.sv
// -----------------------------------------------------------------------------
// setpoint_ramp
//
// Purpose:
//   Moves a registered setpoint toward a latched target in bounded steps, one
//   step every P clocks, so that a downstream PID loop sees a rate-limited
//   setpoint instead of a hard jump. A step of 0 jumps straight to the target.
//   The setpoint never overshoots the target. A new start request retargets.
//   An abort freezes the setpoint and returns to IDLE.
//
// Parameters:
//   SP_WIDTH      setpoint width, signed two's complement (default 12)
//   PERIOD_WIDTH  width of the step-period input (default 16)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   targetIn     in   signed ramp target            (sampled on start only)
//   stepIn       in   unsigned step, 0 = jump       (sampled on start only)
//   periodIn     in   clocks per step, 0 = 1        (sampled on start only)
//   startIn      in   one-cycle start / retarget request
//   abortIn      in   one-cycle abort request (wins over startIn)
//   setpointOut  out  registered signed setpoint
//   busyOut      out  registered, high exactly while in RAMP
//   doneOut      out  registered one-cycle pulse when the target is reached
//   intHoldOut   out  PID integrator hold
//
// Configuration macro:
//   SETPOINT_RAMP_INT_HOLD_EN  when defined, intHoldOut follows busyOut so the
//                              PID integrator is frozen while ramping; when
//                              undefined, intHoldOut is tied low.
// -----------------------------------------------------------------------------
module setpoint_ramp #(
  parameter int SP_WIDTH     = 12,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SP_WIDTH-1:0] targetIn,
  input  logic [SP_WIDTH-2:0]        stepIn,
  input  logic [PERIOD_WIDTH-1:0]    periodIn,
  input  logic                       startIn,
  input  logic                       abortIn,
  output logic signed [SP_WIDTH-1:0] setpointOut,
  output logic                       busyOut,
  output logic                       doneOut,
  output logic                       intHoldOut
);

  localparam int DW = SP_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [SP_WIDTH-1:0]     r_target;
  logic [SP_WIDTH-2:0]     r_step;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_count;
  logic [SP_WIDTH-1:0]     r_setpoint;
  logic                    r_busy;
  logic                    r_done;

  logic [DW-1:0]           w_diff;
  logic [DW-1:0]           w_mag;
  logic [DW-1:0]           w_step_ext;
  logic                    w_jump;
  logic [SP_WIDTH-1:0]     w_next_sp;
  logic [PERIOD_WIDTH-1:0] w_last_count;
  logic                    w_step_edge;

  // Difference is taken one bit wider than the setpoint so that the full
  // span -2048..+2047 (4095) is representable without wrap-around.
  assign w_diff     = {r_target[SP_WIDTH-1], r_target}
                    - {r_setpoint[SP_WIDTH-1], r_setpoint};
  assign w_mag      = w_diff[DW-1] ? ((~w_diff) + {{SP_WIDTH{1'b0}}, 1'b1})
                                   : w_diff;
  assign w_step_ext = {2'b00, r_step};

  // Landing on the target (instead of adding the step) is what prevents
  // overshoot; a zero step also lands directly.
  assign w_jump = (r_step == {(SP_WIDTH-1){1'b0}}) || (w_step_ext >= w_mag);

  // A zero period behaves like a period of one: step on every clock.
  assign w_last_count = (r_period == {PERIOD_WIDTH{1'b0}})
                      ? {PERIOD_WIDTH{1'b0}}
                      : (r_period - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1});
  assign w_step_edge  = (r_count == w_last_count);

  // Next setpoint for a step edge: land on target, or move one step toward it.
  always_comb begin
    w_next_sp = r_setpoint;
    if (w_jump) begin
      w_next_sp = r_target;
    end else if (w_diff[DW-1]) begin
      w_next_sp = r_setpoint - {1'b0, r_step};
    end else begin
      w_next_sp = r_setpoint + {1'b0, r_step};
    end
  end

  // Control FSM with registered setpoint, busy and done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= {PERIOD_WIDTH{1'b0}};
      r_setpoint <= {SP_WIDTH{1'b0}};
      r_target   <= {SP_WIDTH{1'b0}};
      r_step     <= {(SP_WIDTH-1){1'b0}};
      r_period   <= {PERIOD_WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (abortIn) begin
      // Abort wins over start; setpoint is left where it is.
      r_state <= ST_IDLE;
      r_count <= {PERIOD_WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (startIn) begin
      // Start or retarget from any state; a done that would have been
      // produced this cycle is dropped because no step is applied.
      r_state  <= ST_RAMP;
      r_target <= targetIn;
      r_step   <= stepIn;
      r_period <= periodIn;
      r_count  <= {PERIOD_WIDTH{1'b0}};
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        ST_RAMP: begin
          if (w_step_edge) begin
            r_setpoint <= w_next_sp;
            r_count    <= {PERIOD_WIDTH{1'b0}};
            if (w_next_sp == r_target) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RAMP;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_count <= r_count + {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= {PERIOD_WIDTH{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign setpointOut = r_setpoint;
  assign busyOut     = r_busy;
  assign doneOut     = r_done;

`ifdef SETPOINT_RAMP_INT_HOLD_EN
  // The busy register already has exactly the required timing.
  assign intHoldOut = r_busy;
`else
  assign intHoldOut = 1'b0;
`endif

endmodule

// File: tb/tb_setpoint_ramp.sv
module tb_setpoint_ramp;

  logic               clock;
  logic               reset;
  logic signed [11:0] target;
  logic [10:0]        step;
  logic [15:0]        period;
  logic               start;
  logic               abort;
  logic signed [11:0] setpoint;
  logic               busy;
  logic               done;
  logic               hold;

  int checks = 0;
  int errors = 0;

`ifdef SETPOINT_RAMP_INT_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  setpoint_ramp #(.SP_WIDTH(12), .PERIOD_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .targetIn   (target),
    .stepIn     (step),
    .periodIn   (period),
    .startIn    (start),
    .abortIn    (abort),
    .setpointOut(setpoint),
    .busyOut    (busy),
    .doneOut    (done),
    .intHoldOut (hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int exp_sp,
                         input logic exp_busy, input logic exp_done);
    chk({tag, ".sp"},   setpoint, exp_sp);
    chk({tag, ".busy"}, busy,     {31'd0, exp_busy});
    chk({tag, ".done"}, done,     {31'd0, exp_done});
    chk({tag, ".hold"}, hold,     {31'd0, HOLD_EN & exp_busy});
  endtask

  task automatic do_start(input int t, input int s, input int p);
    target = t[11:0];
    step   = s[10:0];
    period = p[15:0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    target = 12'sd0;
    step   = 11'd0;
    period = 16'd0;
    start  = 1'b0;
    abort  = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("idle", 0, 1'b0, 1'b0);

    // Scenario 1: 0 -> 100, step 10, period 4.
    do_start(100, 10, 4);
    chk_out("s1_start", 0, 1'b1, 1'b0);
    target = 12'sd500;   // must be ignored during RAMP
    for (int n = 1; n <= 10; n++) begin
      repeat (3) tick();
      chk_out("s1_wait", 10 * (n - 1), 1'b1, 1'b0);
      tick();
      if (n < 10) chk_out("s1_step", 10 * n, 1'b1, 1'b0);
      else        chk_out("s1_last", 100, 1'b0, 1'b1);
    end
    tick();
    chk_out("s1_after", 100, 1'b0, 1'b0);

    // Jump back to 0 with a zero step.
    do_start(0, 0, 0);
    chk_out("j0_start", 100, 1'b1, 1'b0);
    tick();
    chk_out("j0_land", 0, 1'b0, 1'b1);
    tick();

    // Scenario 2: clamp to -25 without overshoot.
    do_start(-25, 10, 1);
    chk_out("s2_start", 0, 1'b1, 1'b0);
    tick();
    chk_out("s2_a", -10, 1'b1, 1'b0);
    tick();
    chk_out("s2_b", -20, 1'b1, 1'b0);
    tick();
    chk_out("s2_c", -25, 1'b0, 1'b1);
    tick();
    chk_out("s2_after", -25, 1'b0, 1'b0);
    tick();
    chk_out("s2_idle", -25, 1'b0, 1'b0);

    // Scenario 3: full-scale extremes.
    do_start(-2048, 0, 0);
    tick();
    chk_out("s3_min", -2048, 1'b0, 1'b1);
    tick();
    do_start(2047, 2047, 0);
    chk_out("s3_start", -2048, 1'b1, 1'b0);
    tick();
    chk_out("s3_a", -1, 1'b1, 1'b0);
    tick();
    chk_out("s3_b", 2046, 1'b1, 1'b0);
    tick();
    chk_out("s3_c", 2047, 1'b0, 1'b1);
    tick();
    chk_out("s3_after", 2047, 1'b0, 1'b0);

    // Scenario 4: abort and start together at setpoint 40.
    do_start(0, 0, 0);
    tick();
    tick();
    do_start(100, 20, 2);
    tick();
    chk_out("s4_hold", 0, 1'b1, 1'b0);
    tick();
    chk_out("s4_a", 20, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("s4_b", 40, 1'b1, 1'b0);
    abort  = 1'b1;
    target = 12'sd90;
    step   = 11'd5;
    period = 16'd1;
    start  = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_out("s4_abort", 40, 1'b0, 1'b0);
    tick();
    chk_out("s4_frozen", 40, 1'b0, 1'b0);
    do_start(-7, 0, 1);
    chk_out("s4_jstart", 40, 1'b1, 1'b0);
    tick();
    chk_out("s4_jump", -7, 1'b0, 1'b1);
    tick();
    chk_out("s4_jafter", -7, 1'b0, 1'b0);

    // Start with target already reached: DONE without moving.
    do_start(-7, 3, 0);
    chk_out("eq_start", -7, 1'b1, 1'b0);
    tick();
    chk_out("eq_done", -7, 1'b0, 1'b1);
    tick();

    // Scenario 5: retarget mid-ramp reverses direction, counter restarts.
    do_start(50, 10, 3);
    repeat (3) tick();
    chk_out("s5_a", 3, 1'b1, 1'b0);
    repeat (3) tick();
    chk_out("s5_b", 13, 1'b1, 1'b0);
    tick();
    do_start(0, 5, 2);
    chk_out("s5_rt", 13, 1'b1, 1'b0);
    target = 12'sd100;   // ignored
    tick();
    chk_out("s5_restart", 13, 1'b1, 1'b0);
    tick();
    chk_out("s5_c", 8, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("s5_d", 3, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("s5_e", 0, 1'b0, 1'b1);
    tick();

    // Retarget on the edge that would have finished: done is suppressed.
    do_start(10, 0, 0);
    do_start(20, 0, 0);
    chk_out("sup_rt", 0, 1'b1, 1'b0);
    tick();
    chk_out("sup_land", 20, 1'b0, 1'b1);
    tick();

    // Reset mid-ramp, together with a start request.
    do_start(-100, 10, 1);
    tick();
    chk_out("rst_pre", 10, 1'b1, 1'b0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk_out("rst_mid", 0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk_out("rst_after", 0, 1'b0, 1'b0);
    tick();
    chk_out("rst_idle", 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
